pipe_control: RTL

//  Hazard/sequencing controller for the 5-stage Y86-64 pipeline. Computes per-stage stall/bubble

---
 rtl/pipe_control.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipe_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_control                                                    |
// | Brief    : Y86-64 pipeline hazard/stall/bubble control, run-state FSM      |
// |            and saturating performance counters.                            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipe_control #(
  parameter int         CNT_W    = 32,
  parameter logic [3:0] REG_NONE = 4'hF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srca,
  input  logic [3:0]       d_srcb,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstm,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_status,
  input  logic [3:0]       W_icode,
  input  logic [1:0]       W_status,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [1:0]       halt_status,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  localparam logic [3:0]       c_I_NOP    = 4'd1;
  localparam logic [3:0]       c_I_MRMOVQ = 4'd5;
  localparam logic [3:0]       c_I_JXX    = 4'd7;
  localparam logic [3:0]       c_I_RET    = 4'd9;
  localparam logic [3:0]       c_I_POPQ   = 4'd11;
  localparam logic [1:0]       c_S_AOK    = 2'd0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_load_use;
  logic             w_ret_busy;
  logic             w_mispred;
  logic             w_m_exc;
  logic             w_w_exc;
  logic             w_cnt_en;
  logic             w_retire;
  logic [1:0]       r_halt_status;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_ret_cnt;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_mp_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + c_CNT_ONE;
  endfunction

  // Unknown icodes (12..15) match none of these compares, so they never stall.
  assign w_load_use = ((E_icode == c_I_MRMOVQ) || (E_icode == c_I_POPQ)) &&
                      (E_dstm != REG_NONE) &&
                      ((E_dstm == d_srca) || (E_dstm == d_srcb));
  assign w_ret_busy = (D_icode == c_I_RET) || (E_icode == c_I_RET) || (M_icode == c_I_RET);
  assign w_mispred  = (E_icode == c_I_JXX) && !e_cnd;
  assign w_m_exc    = (m_status != c_S_AOK);
  assign w_w_exc    = (W_status != c_S_AOK);
  assign w_cnt_en   = (r_state != ST_HALTED);
  assign w_retire   = (W_status == c_S_AOK) && (W_icode != c_I_NOP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_w_exc)      w_state_nxt = ST_HALTED;
        else if (w_m_exc) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_w_exc) w_state_nxt = ST_HALTED;
      end
      default: w_state_nxt = ST_HALTED;
    endcase
  end

  // Outputs: reset flushes the pipe; HALTED freezes it; otherwise hazard terms.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b0;
    if (reset_n) begin
      if (r_state == ST_HALTED) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b1;
      end else begin
        F_stall  = w_load_use | w_ret_busy;
        D_stall  = w_load_use;
        D_bubble = w_mispred | (w_ret_busy & ~w_load_use);
        E_bubble = w_mispred | w_load_use;
        M_bubble = w_m_exc | w_w_exc;
        W_stall  = w_w_exc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_halt_status <= 2'd0;
    end else if ((r_state != ST_HALTED) && (w_state_nxt == ST_HALTED)) begin
      r_halt_status <= W_status;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
      r_lu_cnt  <= '0;
      r_mp_cnt  <= '0;
    end else if (w_cnt_en) begin
      r_cyc_cnt <= sat_inc(r_cyc_cnt);
      if (w_retire)   r_ret_cnt <= sat_inc(r_ret_cnt);
      if (w_load_use) r_lu_cnt  <= sat_inc(r_lu_cnt);
      if (w_mispred)  r_mp_cnt  <= sat_inc(r_mp_cnt);
    end
  end

  assign halted      = (r_state == ST_HALTED);
  assign halt_status = r_halt_status;
  assign cyc_cnt     = r_cyc_cnt;
  assign ret_cnt     = r_ret_cnt;
  assign lu_cnt      = r_lu_cnt;
  assign mp_cnt      = r_mp_cnt;

endmodule
`default_nettype wire
